// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder.
//   - access size encodings driven by the M stage
//   - FSM state encoding for dmem_resp
//   - is_misaligned(): alignment check used when DMEM_ADDR_CHECK_EN is defined
package dmem_resp_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Size 2'b11 is handled as a word everywhere, so it shares the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a right-aligned core view and the 32-bit SRAM.
// Ports:
//   size, uns, addr_lo : latched access size, zero-extend flag, address bits [1:0]
//   wdata              : right-aligned store data
//   rdata              : raw SRAM word
//   wen                : byte strobes for a store of this size/offset
//   wdata_rep          : store data replicated across all lanes
//   rdata_ext          : selected load lane, sign- or zero-extended
// Half accesses only look at addr_lo[1]; word accesses ignore addr_lo.
module dmem_lane_align
    import dmem_resp_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wen,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        wen       = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (size)
            SZ_BYTE: begin
                wen       = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{~uns & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                wen       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{~uns & half_sel[15]}}, half_sel};
            end
            default: begin
                wen       = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: takes one M-stage load/store at a time, drives a
// synchronous SRAM with latency SRAM_LAT, aligns/extends load data and holds
// the pipeline through stall_req until the access completes.
// Ports:
//   clk, rst           : clock, async active-high reset
//   req_*              : M-stage request (enable, we, size, unsigned, addr, wdata)
//   stall_req          : freeze pipeline
//   resp_valid/rdata   : one-cycle completion pulse, held load result (0 for stores)
//   resp_err           : misaligned access (only with DMEM_ADDR_CHECK_EN)
//   sram_*             : SRAM strobe, byte enables, word address, write data, read data
// Build option: define DMEM_ADDR_CHECK_EN to reject misaligned half/word
// accesses without touching the SRAM; otherwise the low address bits are ignored.
//
// state     | meaning
// ST_IDLE   | waiting; stall_req follows req_en, request latched on req_en
// ST_ACCESS | SRAM strobe in first cycle, wait SRAM_LAT cycles, capture data
// ST_DONE   | resp_valid for one cycle, pipeline released, req_en ignored
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int SRAM_LAT = 1,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall_req,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(SRAM_LAT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              bad_align;
    logic [3:0]        lane_wen;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;

`ifdef DMEM_ADDR_CHECK_EN
    assign bad_align = is_misaligned(req_size, req_addr[1:0]);
`else
    assign bad_align = 1'b0;
`endif

    dmem_lane_align u_align (
        .size      (size_q),
        .uns       (uns_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (sram_rdata),
        .wen       (lane_wen),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_en) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    err_d   = bad_align;
                    if (bad_align) begin
                        state_d = ST_DONE;
                        rdata_d = '0;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAT_CNT) begin
                    state_d = ST_DONE;
                    rdata_d = we_q ? 32'd0 : lane_rdata;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_req  = 1'b0;
        resp_valid = 1'b0;
        sram_en    = 1'b0;
        sram_wen   = 4'b0000;
        case (state_q)
            ST_IDLE:   stall_req = req_en;
            ST_ACCESS: begin
                stall_req = 1'b1;
                if (cnt_q == '0) begin
                    sram_en  = 1'b1;
                    sram_wen = we_q ? lane_wen : 4'b0000;
                end
            end
            ST_DONE:   resp_valid = 1'b1;
            default:   stall_req = 1'b0;
        endcase
    end

    // err_q only ever sets when the alignment check is built in.
    assign resp_err   = (state_q == ST_DONE) & err_q;
    assign resp_rdata = rdata_q;
    assign sram_addr  = {addr_q[31:2], 2'b00};
    assign sram_wdata = lane_wdata;

endmodule
